btb_gshare_predictor: RTL

- Parametrised next-generation branch predictor for the fetch stage: a direct-mapped branch target buffer (BTB) plus a separately indexed pattern history table (PHT) of 2-bit saturating counters.
- Two independent combinational lookup ports, for the two fetch-slot PCs.
- One resolve/update port driven from execute. Adds per-entry valid bits, global flush, configurable depth/tag width and optional global-history (gshare) indexing.

---
 rtl/btb_gshare_predictor_if.sv | 34 +++
 rtl/btb_gshare_predictor.sv | 110 +++++++++++
 2 files changed

// File: rtl/btb_gshare_predictor_if.sv
// rtl/btb_gshare_predictor_if.sv - lookup, resolve and flush signals of the BTB/gshare branch predictor
interface btb_gshare_predictor_if #(
  parameter int GHR_W = 6
) ();
  logic [31:0]      rd_addr0_i;
  logic             rd_hit0_o;
  logic             rd_taken0_o;
  logic [31:0]      rd_target0_o;
  logic [31:0]      rd_addr1_i;
  logic             rd_hit1_o;
  logic             rd_taken1_o;
  logic [31:0]      rd_target1_o;
  logic [GHR_W-1:0] ghr_o;
  logic             upd_valid_i;
  logic             upd_taken_i;
  logic [31:0]      upd_addr_i;
  logic [31:0]      upd_target_i;
  logic [GHR_W-1:0] upd_ghr_i;
  logic             flush_i;

  modport master (
    output rd_addr0_i, rd_addr1_i, upd_valid_i, upd_taken_i, upd_addr_i,
           upd_target_i, upd_ghr_i, flush_i,
    input  rd_hit0_o, rd_taken0_o, rd_target0_o, rd_hit1_o, rd_taken1_o,
           rd_target1_o, ghr_o
  );

  modport slave (
    input  rd_addr0_i, rd_addr1_i, upd_valid_i, upd_taken_i, upd_addr_i,
           upd_target_i, upd_ghr_i, flush_i,
    output rd_hit0_o, rd_taken0_o, rd_target0_o, rd_hit1_o, rd_taken1_o,
           rd_target1_o, ghr_o
  );
endinterface

// File: rtl/btb_gshare_predictor.sv
// rtl/btb_gshare_predictor.sv - direct-mapped BTB plus 2-bit PHT, two lookup ports, one update port
// Optional global-history (gshare) indexing enabled by defining BP_GSHARE_EN.
module btb_gshare_predictor #(
  parameter int IDX_W     = 2,
  parameter int TAG_W     = 8,
  parameter int PHT_IDX_W = 6,
  parameter int GHR_W     = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  btb_gshare_predictor_if.slave bp
);
  localparam int BTB_N = 1 << IDX_W;
  localparam int PHT_N = 1 << PHT_IDX_W;

  logic                 btb_valid [BTB_N];
  logic [TAG_W-1:0]     btb_tag   [BTB_N];
  logic [31:0]          btb_tgt   [BTB_N];
  logic [1:0]           pht       [PHT_N];

  logic [PHT_IDX_W-1:0] rd_hist;
  logic [PHT_IDX_W-1:0] upd_hist;
  logic                 upd_en;

  assign upd_en = bp.upd_valid_i && !bp.flush_i;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (bp.flush_i) begin
      ghr <= '0;
    end else if (bp.upd_valid_i) begin
      ghr <= {ghr[GHR_W-2:0], bp.upd_taken_i};
    end
  end

  assign rd_hist  = PHT_IDX_W'(ghr);
  assign upd_hist = PHT_IDX_W'(bp.upd_ghr_i);
  assign bp.ghr_o = ghr;
`else
  wire unused_upd_ghr = ^bp.upd_ghr_i;

  assign rd_hist  = '0;
  assign upd_hist = '0;
  assign bp.ghr_o = '0;
`endif

  logic [IDX_W-1:0]     rd_idx0, rd_idx1, upd_idx;
  logic [PHT_IDX_W-1:0] rd_pi0, rd_pi1, upd_pi;
  logic [1:0]           pht_next;

  always_comb begin
    rd_idx0 = bp.rd_addr0_i[IDX_W:1];
    rd_idx1 = bp.rd_addr1_i[IDX_W:1];
    upd_idx = bp.upd_addr_i[IDX_W:1];
    rd_pi0  = bp.rd_addr0_i[PHT_IDX_W:1] ^ rd_hist;
    rd_pi1  = bp.rd_addr1_i[PHT_IDX_W:1] ^ rd_hist;
    upd_pi  = bp.upd_addr_i[PHT_IDX_W:1] ^ upd_hist;
  end

  // Reads come straight from registered state: an update is only visible after its edge.
  assign bp.rd_hit0_o    = btb_valid[rd_idx0] &&
                           (btb_tag[rd_idx0] == bp.rd_addr0_i[IDX_W+TAG_W:IDX_W+1]);
  assign bp.rd_taken0_o  = bp.rd_hit0_o && pht[rd_pi0][1];
  assign bp.rd_target0_o = btb_tgt[rd_idx0];
  assign bp.rd_hit1_o    = btb_valid[rd_idx1] &&
                           (btb_tag[rd_idx1] == bp.rd_addr1_i[IDX_W+TAG_W:IDX_W+1]);
  assign bp.rd_taken1_o  = bp.rd_hit1_o && pht[rd_pi1][1];
  assign bp.rd_target1_o = btb_tgt[rd_idx1];

  always_comb begin
    pht_next = pht[upd_pi];
    if (bp.upd_taken_i && (pht[upd_pi] != 2'b11)) begin
      pht_next = pht[upd_pi] + 2'd1;
    end else if (!bp.upd_taken_i && (pht[upd_pi] != 2'b00)) begin
      pht_next = pht[upd_pi] - 2'd1;
    end
  end

  // Flush clears valid bits only; PHT counters and targets survive it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid[i] <= 1'b0;
        btb_tag[i]   <= '0;
        btb_tgt[i]   <= '0;
      end
      for (int j = 0; j < PHT_N; j++) begin
        pht[j] <= 2'b01;
      end
    end else if (bp.flush_i) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid[i] <= 1'b0;
      end
    end else if (upd_en) begin
      pht[upd_pi] <= pht_next;
      if (bp.upd_taken_i) begin
        btb_valid[upd_idx] <= 1'b1;
        btb_tag[upd_idx]   <= bp.upd_addr_i[IDX_W+TAG_W:IDX_W+1];
        btb_tgt[upd_idx]   <= {bp.upd_target_i[31:1], 1'b0};
      end
    end
  end

  wire unused_addr_bits = ^{bp.rd_addr0_i, bp.rd_addr1_i, bp.upd_addr_i, bp.upd_target_i[0]};

endmodule
